// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and helpers for the ROM read arbiter and its round-robin picker.
package rom_read_arbiter_pkg;

  // Transaction sequencer: one ROM read occupies exactly these four states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROM_RD  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request bit found by
// scanning last+1, last+2, ... wrapping modulo NREQ wins.
module rr_picker
  import rom_read_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // One extra bit so last+k (at most 2*NREQ-1) cannot overflow before the wrap.
  logic [IW:0] cand;

  // Scan from the requester after the previous winner; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves a
    // value unassigned and no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = {1'b0, last_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                = 1'b1;
        idx_o                = cand[IW-1:0];
        gnt_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM among NREQ clients.
// Each grant walks IDLE -> ROM_RD -> CAPTURE -> ACK; the winner sees a
// one-cycle ack with the read word (or rerr for out-of-range addresses).
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               rerr,
  output logic               busy,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data
);

  localparam int unsigned IW      = idx_w(NREQ);
  // Range limit widened by one bit so DEPTH == 2**AW is representable and
  // the compare below can then never fire.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("rom_read_arbiter: NREQ must be in 2..8");
    end
    if (longint'(DEPTH) > (longint'(1) << AW)) begin : g_bad_depth
      $error("rom_read_arbiter: DEPTH must not exceed 2**AW");
    end
  endgenerate

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            oor_q, oor_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [AW-1:0]   win_addr;

  // Unpack the flat address bus so the winner's address is a plain array read.
  generate
    for (genvar i = 0; i < int'(NREQ); i++) begin : g_addr
      assign addr_arr[i] = addr[i*AW +: AW];
    end
  endgenerate

  assign win_addr = addr_arr[pick_idx];

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Next-state and datapath: grant in IDLE, wait for the ROM, capture, ack.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    win_d      = win_q;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    oor_d      = oor_q;
    ack_d      = ack_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d      = pick_gnt;
          win_d      = pick_idx;
          rom_addr_d = win_addr;
          oor_d      = ({1'b0, win_addr} >= DEPTH_C);
          state_d    = ROM_RD;
        end
      end
      // The ROM samples rom_addr at the closing edge of this cycle.
      ROM_RD: state_d = CAPTURE;
      CAPTURE: begin
        // Out-of-range reads never trust whatever the ROM drives.
        rdata_d = oor_q ? '0 : rom_data;
        rerr_d  = oor_q;
        ack_d   = gnt_q;
        last_d  = win_q;
        state_d = ACK;
      end
      ACK: begin
        ack_d   = '0;
        rerr_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any transaction and restarts at requester 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      win_q      <= '0;
      last_q     <= IW'(NREQ - 1);
      rom_addr_q <= '0;
      oor_q      <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed in the previous cycle, independent of statement order.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      win_q      <= win_d;
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      oor_q      <= oor_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign rerr     = rerr_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != IDLE);

endmodule
